// File: rtl/tausworthe_ctrl.sv
// tausworthe_ctrl: owns the three Tausworthe state words, sanitises seeds,
// discards warm-up outputs and shares one word per cycle among NREQ
// requesters through a round-robin arbiter.
module tausworthe_ctrl #(
    parameter int          NREQ      = 4,
    parameter int          WARMUP    = 8,
    parameter logic [31:0] SEED0_DEF = 32'h0000_1234,
    parameter logic [31:0] SEED1_DEF = 32'h0000_5678,
    parameter logic [31:0] SEED2_DEF = 32'h0009_ABCD
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ce,
    input  logic            seed_load,
    input  logic [31:0]     seed0,
    input  logic [31:0]     seed1,
    input  logic [31:0]     seed2,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic            rnd_valid,
    output logic [31:0]     rnd_data,
    output logic            ready
);

    localparam int unsigned NR     = NREQ;
    localparam int unsigned PW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0]  WARM_N = 8'(WARMUP);

    typedef enum logic {
        ST_WARM,
        ST_RUN
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [31:0]     s0_q, s0_d;
    logic [31:0]     s1_q, s1_d;
    logic [31:0]     s2_q, s2_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            valid_q, valid_d;
    logic [31:0]     data_q, data_d;
    logic            ready_q, ready_d;

    logic [31:0]     s0_nx, s1_nx, s2_nx, word_nx;
    logic [31:0]     seed0_san, seed1_san, seed2_san;
    logic            hit;
    logic [PW-1:0]   sel;
    logic [PW-1:0]   idx;

    // One generator step from the current state, plus sanitised seed values
    always_comb begin
        s0_nx   = ((s0_q & 32'hFFFF_FFFE) << 12) ^ (((s0_q << 13) ^ s0_q) >> 19);
        s1_nx   = ((s1_q & 32'hFFFF_FFF8) << 4)  ^ (((s1_q << 2)  ^ s1_q) >> 25);
        s2_nx   = ((s2_q & 32'hFFFF_FFF0) << 17) ^ (((s2_q << 3)  ^ s2_q) >> 11);
        word_nx = s0_nx ^ s1_nx ^ s2_nx;

        seed0_san = (seed0 < 32'd2)  ? (seed0 | 32'd2)  : seed0;
        seed1_san = (seed1 < 32'd8)  ? (seed1 | 32'd8)  : seed1;
        seed2_san = (seed2 < 32'd16) ? (seed2 | 32'd16) : seed2;
    end

    // Round-robin pick: first requester at or after the priority pointer
    always_comb begin
        hit = 1'b0;
        sel = '0;
        idx = '0;
        for (int unsigned k = 0; k < NR; k++) begin
            idx = PW'((32'(ptr_q) + k) % NR);
            if (!hit && req[idx]) begin
                hit = 1'b1;
                sel = idx;
            end
        end
    end

    // Next-state: seed load beats everything, ce gates stepping and granting
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        ptr_d   = ptr_q;
        gnt_d   = '0;
        valid_d = 1'b0;
        data_d  = data_q;

        if (seed_load) begin
            s0_d    = seed0_san;
            s1_d    = seed1_san;
            s2_d    = seed2_san;
            cnt_d   = '0;
            state_d = ST_WARM;
        end else if (ce) begin
            case (state_q)
                ST_WARM: begin
                    // Transition cycle does not step, so WARMUP=0 never steps
                    if (cnt_q == WARM_N) begin
                        state_d = ST_RUN;
                    end else begin
                        s0_d  = s0_nx;
                        s1_d  = s1_nx;
                        s2_d  = s2_nx;
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_RUN: begin
                    if (hit) begin
                        s0_d       = s0_nx;
                        s1_d       = s1_nx;
                        s2_d       = s2_nx;
                        gnt_d[sel] = 1'b1;
                        valid_d    = 1'b1;
                        data_d     = word_nx;
                        ptr_d      = (sel == PW'(NR - 1)) ? '0 : sel + 1'b1;
                    end
                end
                default: state_d = ST_WARM;
            endcase
        end

        ready_d = (state_d == ST_RUN);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WARM;
            cnt_q   <= '0;
            s0_q    <= SEED0_DEF;
            s1_q    <= SEED1_DEF;
            s2_q    <= SEED2_DEF;
            ptr_q   <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ready_q <= ready_d;
        end
    end

    assign gnt       = gnt_q;
    assign rnd_valid = valid_q;
    assign rnd_data  = data_q;
    assign ready     = ready_q;

endmodule

// File: tb/tb_tausworthe_ctrl.sv
// Self-checking bench for tausworthe_ctrl: directed steps plus randomized
// traffic checked against a cycle-level reference model of the controller.
module tb_tausworthe_ctrl;

    localparam int NREQ   = 4;
    localparam int WARMUP = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ce;
    logic            seed_load;
    logic [31:0]     seed0, seed1, seed2;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic            rnd_valid;
    logic [31:0]     rnd_data;
    logic            ready;

    // second instance with no warm-up, used for the known-answer vectors
    logic            b_ce;
    logic            b_seed_load;
    logic [31:0]     b_seed0, b_seed1, b_seed2;
    logic [NREQ-1:0] b_req;
    logic [NREQ-1:0] b_gnt;
    logic            b_valid;
    logic [31:0]     b_data;
    logic            b_ready;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [31:0]     m_s [3];
    int              m_cnt;
    bit              m_run;
    int              m_ptr;
    logic [NREQ-1:0] m_gnt;
    logic            m_valid;
    logic [31:0]     m_data;

    logic [31:0]     rec [8];

    always #5 clk = ~clk;

    tausworthe_ctrl #(.NREQ(NREQ), .WARMUP(WARMUP)) u_dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .seed_load(seed_load),
        .seed0(seed0), .seed1(seed1), .seed2(seed2), .req(req),
        .gnt(gnt), .rnd_valid(rnd_valid), .rnd_data(rnd_data), .ready(ready)
    );

    tausworthe_ctrl #(.NREQ(NREQ), .WARMUP(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .ce(b_ce), .seed_load(b_seed_load),
        .seed0(b_seed0), .seed1(b_seed1), .seed2(b_seed2), .req(b_req),
        .gnt(b_gnt), .rnd_valid(b_valid), .rnd_data(b_data), .ready(b_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sanit(input logic [31:0] v, input logic [31:0] lim);
        return (v < lim) ? (v | (lim >> 2) * 2) : v;
    endfunction

    // advance the three generator words by one step and return the output word
    function automatic logic [31:0] mstep();
        logic [31:0] a, b, c, n0, n1, n2;
        a  = m_s[0];
        b  = m_s[1];
        c  = m_s[2];
        n0 = ((a & 32'hFFFF_FFFE) << 12) ^ (((a << 13) ^ a) >> 19);
        n1 = ((b & 32'hFFFF_FFF8) << 4)  ^ (((b << 2)  ^ b) >> 25);
        n2 = ((c & 32'hFFFF_FFF0) << 17) ^ (((c << 3)  ^ c) >> 11);
        m_s[0] = n0;
        m_s[1] = n1;
        m_s[2] = n2;
        return n0 ^ n1 ^ n2;
    endfunction

    task automatic model_reset();
        m_s[0]  = 32'h0000_1234;
        m_s[1]  = 32'h0000_5678;
        m_s[2]  = 32'h0009_ABCD;
        m_cnt   = 0;
        m_run   = 0;
        m_ptr   = 0;
        m_gnt   = '0;
        m_valid = 0;
        m_data  = '0;
    endtask

    task automatic model_update();
        int who;
        m_gnt   = '0;
        m_valid = 0;
        if (seed_load) begin
            m_s[0] = (seed0 < 2)  ? (seed0 | 32'd2)  : seed0;
            m_s[1] = (seed1 < 8)  ? (seed1 | 32'd8)  : seed1;
            m_s[2] = (seed2 < 16) ? (seed2 | 32'd16) : seed2;
            m_cnt  = 0;
            m_run  = 0;
        end else if (ce) begin
            if (!m_run) begin
                if (m_cnt == WARMUP) m_run = 1;
                else begin
                    void'(mstep());
                    m_cnt++;
                end
            end else begin
                who = -1;
                for (int k = 0; k < NREQ; k++)
                    if (who < 0 && req[(m_ptr + k) % NREQ]) who = (m_ptr + k) % NREQ;
                if (who >= 0) begin
                    m_gnt[who] = 1'b1;
                    m_valid    = 1;
                    m_data     = mstep();
                    m_ptr      = (who + 1) % NREQ;
                end
            end
        end
    endtask

    // one clock: model follows the edge, outputs checked 1 time unit later
    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_update();
        #1;
        check("gnt",   32'(gnt),       32'(m_gnt));
        check("valid", 32'(rnd_valid), 32'(m_valid));
        check("data",  rnd_data,       m_data);
        check("ready", 32'(ready),     32'(m_run));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit got;

        rst_n = 0; ce = 1; seed_load = 0; req = '0;
        seed0 = '0; seed1 = '0; seed2 = '0;
        b_ce = 1; b_seed_load = 0; b_req = '0;
        b_seed0 = '0; b_seed1 = '0; b_seed2 = '0;
        model_reset();

        // reset values
        #1;
        check("rst_gnt",   32'(gnt),       32'd0);
        check("rst_valid", 32'(rnd_valid), 32'd0);
        check("rst_data",  rnd_data,       32'd0);
        check("rst_ready", 32'(ready),     32'd0);
        tick();
        tick();
        rst_n = 1;

        // warm-up with no requests; second instance runs the known vectors
        for (int t = 0; t < 9; t++) begin
            b_seed_load = (t == 0);
            b_req       = (t == 2 || t == 3) ? 4'b0001 : 4'b0000;
            tick();
            if (t == 0) check("b_ready_load", 32'(b_ready), 32'd0);
            if (t == 1) check("b_ready_run",  32'(b_ready), 32'd1);
            if (t == 2) begin
                check("b_gnt1",  32'(b_gnt),   32'd1);
                check("b_valid", 32'(b_valid), 32'd1);
                check("b_word1", b_data,       32'h0020_2080);
            end
            if (t == 3) check("b_word2", b_data, 32'h0200_2C80);
            if (t == 7) check("ready_pre", 32'(ready), 32'd0);
            if (t == 8) check("ready_edge8", 32'(ready), 32'd1);
        end
        b_seed_load = 0;
        b_req       = '0;

        // all requesting: round-robin sequence, recorded for the restart check
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("rr_gnt", 32'(gnt), 32'(1) << (k % 4));
            rec[k] = rnd_data;
        end
        req = '0;

        // ce toggling with req[2] held
        req = 4'b0100;
        ce = 1; tick();
        ce = 0; tick();
        check("ce0_gnt", 32'(gnt), 32'd0);
        ce = 1; tick();
        req = '0;

        // seed load collides with req[1]
        seed_load = 1; seed0 = 32'd1; seed1 = 32'd3; seed2 = 32'hDEAD_BEEF;
        req = 4'b0010;
        tick();
        check("load_gnt",   32'(gnt),   32'd0);
        check("load_ready", 32'(ready), 32'd0);
        seed_load = 0;
        n = 0; got = 0;
        while (!got && n < 20) begin
            tick();
            n++;
            if (gnt[1]) got = 1;
        end
        check("load_wait", 32'(n), 32'(WARMUP + 2));
        req = '0;

        // randomized traffic
        for (int k = 0; k < 300; k++) begin
            ce        = ($urandom % 8) != 0;
            seed_load = ($urandom % 40) == 0;
            seed0     = ($urandom % 4 == 0) ? $urandom % 20 : $urandom;
            seed1     = ($urandom % 4 == 0) ? $urandom % 20 : $urandom;
            seed2     = ($urandom % 4 == 0) ? $urandom % 20 : $urandom;
            req       = ($urandom % 5 == 0) ? '0 : 4'($urandom);
            tick();
        end
        seed_load = 0;
        ce = 1;

        // mid-stream asynchronous reset with requests active
        req = 4'b1111;
        for (int k = 0; k < 12; k++) tick();
        check("pre_rst_valid", 32'(rnd_valid), 32'd1);
        #2;
        rst_n = 0;
        #1;
        check("async_gnt",   32'(gnt),       32'd0);
        check("async_valid", 32'(rnd_valid), 32'd0);
        model_reset();
        req = '0;
        tick();
        rst_n = 1;

        // restart sequence must match the one after the first reset
        for (int k = 0; k < 9; k++) tick();
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("restart_word", rnd_data, rec[k]);
        end
        req = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tausworthe_ctrl.md
# tausworthe_ctrl

Sequencing and sharing controller for the combined three-component Tausworthe uniform RNG. It owns the three 32-bit generator state words, loads and sanitises seeds, and discards a configurable number of warm-up outputs. It then hands one 32-bit random word per cycle to up to NREQ requesters under round-robin arbitration. It sits between the seed/configuration source and the downstream consumers (e.g. Box-Muller or noise-injection stages) that previously drove the generator directly.

## Interface
- NREQ, 4, number of requesters (1..16)
- WARMUP, 8, generator steps discarded after every seed load (0..255)
- SEED0_DEF, 32'h0000_1234, reset value of s0
- SEED1_DEF, 32'h0000_5678, reset value of s1
- SEED2_DEF, 32'h0009_ABCD, reset value of s2
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ce  in  1  clock enable for stepping, warm-up counting and granting
- seed_load  in  1  load seed0..seed2 on this edge
- seed0, seed1, seed2  in  32 each  seed values
- req  in  NREQ  per-requester request, held until granted
- gnt  out  NREQ  one-hot grant pulse, registered
- rnd_valid  out  1  rnd_data valid, coincident with gnt
- rnd_data  out  32  random word for the granted requester
- ready  out  1  high in RUN state (warm-up complete)

## Operation
- Step function, 32-bit arithmetic, shifted-out bits discarded:
  - b0=((s0<<13)^s0)>>19; s0'=((s0&FFFFFFFE)<<12)^b0
  - b1=((s1<<2)^s1)>>25; s1'=((s1&FFFFFFF8)<<4)^b1
  - b2=((s2<<3)^s2)>>11; s2'=((s2&FFFFFFF0)<<17)^b2
  - output word = s0'^s1'^s2'. A step commits s0',s1',s2' to the state registers.
- Seed sanitising on load:
  - seed0<2 → seed0|2
  - seed1<8 → seed1|8
  - seed2<16 → seed2|16
  - Other values pass unchanged.
- States:
  - WARM: each ce=1 cycle steps once and increments the warm counter. When the counter reaches WARMUP, go to RUN. WARMUP=0 goes to RUN on the first cycle without stepping.
  - RUN: each ce=1 cycle with any req bit set grants exactly one requester, steps once and returns that step's output word. No request means no step.
- seed_load:
  - Sampled every cycle, regardless of ce or state.
  - On the next edge: state registers take the sanitised seeds, warm counter clears, state becomes WARM.
  - Load has priority over a same-cycle grant: no grant or step that cycle.
  - The round-robin pointer is not reset by seed_load.
- Arbitration:
  - Round-robin. The priority pointer starts at requester 0.
  - After granting requester i, highest priority moves to (i+1) mod NREQ.
  - A requester holding req is granted within NREQ ce-active RUN cycles.
- ce=0: no step, no count, no grant. gnt and rnd_valid deassert. Registers and pointer hold.

## Timing
- Reset values:
  - state WARM, s0/s1/s2 = SEED*_DEF (unsanitised, the defaults are already legal), warm counter 0, pointer 0.
  - gnt=0, rnd_valid=0, rnd_data=0, ready=0.
- Latency:
  - req sampled at edge N → gnt, rnd_valid and rnd_data present after edge N+1, for one cycle.
  - A requester deasserts req in the cycle after seeing gnt, or it is eligible again.
- Throughput: one word per cycle. Consecutive grants to different requesters are back-to-back with no bubble.
- rnd_data holds its last value when rnd_valid=0.
- ready:
  - Rises on the edge that enters RUN.
  - Falls on the edge that applies seed_load.
- Reset asserted mid-operation clears gnt and rnd_valid immediately (async) and restarts warm-up from the default seeds.

## Test plan
- Reset release, WARMUP=8, ce=1, no req → ready rises after edge 8 (9th edge from release if the first edge is counted 0). gnt stays 0 throughout.
- WARMUP=0, seed_load with seeds 0,0,0 (sanitised to 2,8,16), then req[0] held one cycle → rnd_data=32'h0020_2080. A second request → 32'h0200_2C80.
- RUN, req=4'b1111 held for 8 ce cycles → gnt sequence 0001,0010,0100,1000,0001,… with rnd_valid high every cycle.
- RUN, req[2] held, ce toggled 1,0,1 → grant only in ce=1 cycles. The generator state is unchanged across the ce=0 cycle, so the next word equals the single-step successor.
- seed_load asserted in the same cycle as req[1] during RUN → no gnt that cycle, ready falls, and WARMUP steps elapse before req[1] is granted.
- rst_n pulsed low mid-stream with req active → gnt and rnd_valid drop without waiting for a clock edge. The sequence after warm-up restarts identically to the one after the initial reset.
